// File: rtl/prs_tx_feeder.sv
// prs_tx_feeder
//
// Event-counting data source for the SPI slave TX path. Four asynchronous
// event lines are synchronized and rising-edge counted. The SPI slave's
// received 2-bit command selects which counter is reported. On a TX request
// the selected counter is snapshotted into a frame of the form
// {sel[1:0], seq[1:0], cnt[sel]}, presented with a valid flag, and the
// snapshotted counter and its overflow flag are cleared.
//
// Optional build macro:
//   PRS_FEEDER_SAT_EN - counters saturate at all-ones instead of wrapping.
//                       Either way, o_ovf is set when a counter would pass
//                       all-ones.
//
// Parameters:
//   CNT_BITS     width of each event counter (frame is CNT_BITS+4 wide)
//   SYNC_STAGES  synchronizer depth for i_evt and i_rx_valid (must be >= 2)
//
// Ports:
//   i_clk       system clock (same clock as the SPI slave FSM)
//   i_rst       asynchronous active-high reset
//   i_evt       asynchronous event inputs, one per channel
//   i_tx_req    TX data request from the slave
//   o_tx_word   frame to the slave
//   o_tx_valid  frame valid to the slave
//   i_rx_cmd    received channel command (SCK domain, stable when sampled)
//   i_rx_valid  received command valid (SCK domain)
//   o_sel       currently selected channel
//   o_ovf       per-channel sticky overflow flags

module prs_tx_feeder #(
  parameter int CNT_BITS    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [3:0]            i_evt,
  input  logic                  i_tx_req,
  output logic [CNT_BITS+3:0]   o_tx_word,
  output logic                  o_tx_valid,
  input  logic [1:0]            i_rx_cmd,
  input  logic                  i_rx_valid,
  output logic [1:0]            o_sel,
  output logic [3:0]            o_ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [3:0]            evt_sync [SYNC_STAGES];
  logic [3:0]            evt_prev;
  logic [3:0]            evt_rise;
  logic [SYNC_STAGES-1:0] rxv_sync;
  logic                  rxv_prev;
  logic                  rxv_rise;

  logic [CNT_BITS-1:0]   cnt [4];
  logic [3:0]            ovf;
  logic [1:0]            sel;
  logic [1:0]            seq;
  logic [1:0]            state;
  logic                  snap;

  // Event synchronizers plus one extra flop for rising-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) evt_sync[s] <= '0;
      evt_prev <= '0;
    end else begin
      evt_sync[0] <= i_evt;
      for (int s = 1; s < SYNC_STAGES; s++) evt_sync[s] <= evt_sync[s-1];
      evt_prev <= evt_sync[SYNC_STAGES-1];
    end
  end

  assign evt_rise = evt_sync[SYNC_STAGES-1] & ~evt_prev;

  // The command valid crosses from the SCK domain the same way. The command
  // bits themselves are sampled unsynchronized: the SCK period is slow enough
  // that they have been stable for several cycles by the time the
  // synchronized valid edge appears.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rxv_sync <= '0;
      rxv_prev <= 1'b0;
      sel      <= 2'd0;
    end else begin
      rxv_sync <= {rxv_sync[SYNC_STAGES-2:0], i_rx_valid};
      rxv_prev <= rxv_sync[SYNC_STAGES-1];
      if (rxv_rise) sel <= i_rx_cmd;
    end
  end

  assign rxv_rise = rxv_sync[SYNC_STAGES-1] & ~rxv_prev;

  // Snapshot happens on the LOAD cycle only if the request is still held.
  assign snap = (state == LOAD) && i_tx_req;

  // Counters. On the snapshot cycle the selected counter restarts from the
  // concurrent edge (if any), so an edge coinciding with the snapshot lands
  // in the next frame rather than being lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int n = 0; n < 4; n++) cnt[n] <= '0;
      ovf <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (snap && (sel == 2'(n))) begin
          cnt[n] <= evt_rise[n] ? CNT_BITS'(1) : '0;
          ovf[n] <= 1'b0;
        end else if (evt_rise[n]) begin
          if (cnt[n] == '1) begin
            ovf[n] <= 1'b1;
`ifdef PRS_FEEDER_SAT_EN
            cnt[n] <= cnt[n];
`else
            cnt[n] <= '0;
`endif
          end else begin
            cnt[n] <= cnt[n] + 1'b1;
          end
        end
      end
    end
  end

  // Request FSM and frame register. The valid flag is registered from the
  // state, so it rises one cycle after entering HOLD (frame already stable)
  // and falls one cycle after the FSM leaves HOLD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      seq        <= 2'd0;
      o_tx_word  <= '0;
      o_tx_valid <= 1'b0;
    end else begin
      o_tx_valid <= (state == HOLD);
      case (state)
        IDLE: begin
          if (i_tx_req) state <= LOAD;
        end
        LOAD: begin
          if (i_tx_req) begin
            o_tx_word <= {sel, seq, cnt[sel]};
            seq       <= seq + 1'b1;
            state     <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (!i_tx_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_sel = sel;
  assign o_ovf = ovf;

endmodule

// File: tb/tb_prs_tx_feeder.sv
// tb_prs_tx_feeder
//
// Directed self-checking bench for prs_tx_feeder (CNT_BITS=12, SYNC_STAGES=2).
// Inputs are driven on the falling clock edge and outputs are sampled there.
// Frame constants are hand-computed as {sel, seq, count}; the scenarios run
// in a fixed order so the seq field of every frame is known in advance.

module tb_prs_tx_feeder;

  localparam int CNT_BITS    = 12;
  localparam int SYNC_STAGES = 2;
  localparam int W           = CNT_BITS + 4;

`ifdef PRS_FEEDER_SAT_EN
  localparam logic [W-1:0] OVF_FRAME = 16'h4FFF;
`else
  localparam logic [W-1:0] OVF_FRAME = 16'h4001;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [3:0]    i_evt;
  logic          i_tx_req;
  logic [W-1:0]  o_tx_word;
  logic          o_tx_valid;
  logic [1:0]    i_rx_cmd;
  logic          i_rx_valid;
  logic [1:0]    o_sel;
  logic [3:0]    o_ovf;

  int checks = 0;
  int errors = 0;

  prs_tx_feeder #(
    .CNT_BITS    (CNT_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_evt      (i_evt),
    .i_tx_req   (i_tx_req),
    .o_tx_word  (o_tx_word),
    .o_tx_valid (o_tx_valid),
    .i_rx_cmd   (i_rx_cmd),
    .i_rx_valid (i_rx_valid),
    .o_sel      (o_sel),
    .o_ovf      (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // n clean pulses (2 cycles high, 2 low), then let the last edge reach the counter.
  task automatic pulse_evt(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      i_evt[ch] = 1'b1;
      repeat (2) @(negedge i_clk);
      i_evt[ch] = 1'b0;
      repeat (2) @(negedge i_clk);
    end
    repeat (SYNC_STAGES + 2) @(negedge i_clk);
  endtask

  // Full request/handshake; returns the presented frame.
  task automatic get_frame(output logic [W-1:0] w);
    int waited;
    w = '0;
    waited = 0;
    i_tx_req = 1'b1;
    while (o_tx_valid !== 1'b1 && waited < 8) begin
      @(negedge i_clk);
      waited++;
    end
    checks++;
    if (o_tx_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_timeout: o_tx_valid=%b required 1", o_tx_valid);
    end
    w = o_tx_word;
    i_tx_req = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_evt = 4'b0;
    i_tx_req = 1'b0;
    i_rx_cmd = 2'b0;
    i_rx_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_tx_valid); end
    checks++;
    if (o_tx_word !== 16'h0000) begin errors++; $display("[TB] FAIL reset_word: got %h expected 0000", o_tx_word); end
    checks++;
    if (o_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", o_sel); end
    checks++;
    if (o_ovf !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0000", o_ovf); end
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] w;
    pulse_evt(0, 5);
    i_tx_req = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_edge1: got %b expected 0", o_tx_valid); end
    @(negedge i_clk);
    checks++;
    if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_edge2: got %b expected 0", o_tx_valid); end
    @(negedge i_clk);
    checks++;
    if (o_tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_edge3: got %b expected 1", o_tx_valid); end
    checks++;
    if (o_tx_word !== 16'h0005) begin errors++; $display("[TB] FAIL basic_word: got %h expected 0005", o_tx_word); end
    i_tx_req = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_fall: got %b expected 0", o_tx_valid); end
    @(negedge i_clk);
    get_frame(w);
    checks++;
    if (w !== 16'h1000) begin errors++; $display("[TB] FAIL basic_second_frame: got %h expected 1000", w); end
  endtask

  task automatic test_command_select();
    logic [W-1:0] w;
    i_rx_cmd = 2'b10;
    i_rx_valid = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_sel !== 2'd0) begin errors++; $display("[TB] FAIL sel_early: got %0d expected 0", o_sel); end
    @(negedge i_clk);
    checks++;
    if (o_sel !== 2'd2) begin errors++; $display("[TB] FAIL sel_latency: got %0d expected 2", o_sel); end
    repeat (2) @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    pulse_evt(2, 3);
    get_frame(w);
    checks++;
    if (w !== 16'hA003) begin errors++; $display("[TB] FAIL cmd_frame: got %h expected a003", w); end
  endtask

  task automatic test_aborted_request();
    logic [W-1:0] w;
    logic seen_valid;
    pulse_evt(2, 2);
    seen_valid = 1'b0;
    i_tx_req = 1'b1;
    @(negedge i_clk);
    i_tx_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (o_tx_valid === 1'b1) seen_valid = 1'b1;
      @(negedge i_clk);
    end
    checks++;
    if (seen_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b expected 0", seen_valid); end
    get_frame(w);
    checks++;
    if (w !== 16'hB002) begin errors++; $display("[TB] FAIL abort_frame: got %h expected b002", w); end
  endtask

  task automatic test_snapshot_collision();
    logic [W-1:0] w;
    i_evt[2] = 1'b1;
    @(negedge i_clk);
    get_frame(w);
    checks++;
    if (w !== 16'h8000) begin errors++; $display("[TB] FAIL collision_frame: got %h expected 8000", w); end
    i_evt[2] = 1'b0;
    repeat (4) @(negedge i_clk);
    get_frame(w);
    checks++;
    if (w !== 16'h9001) begin errors++; $display("[TB] FAIL collision_next_frame: got %h expected 9001", w); end
  endtask

  task automatic test_sel_during_load();
    logic [W-1:0] w;
    pulse_evt(2, 1);
    pulse_evt(1, 3);
    i_rx_cmd = 2'b01;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    get_frame(w);
    checks++;
    if (w !== 16'hA001) begin errors++; $display("[TB] FAIL selload_frame: got %h expected a001", w); end
    checks++;
    if (o_sel !== 2'd1) begin errors++; $display("[TB] FAIL selload_sel: got %0d expected 1", o_sel); end
    i_rx_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    get_frame(w);
    checks++;
    if (w !== 16'h7003) begin errors++; $display("[TB] FAIL selload_next_frame: got %h expected 7003", w); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] w;
    pulse_evt(1, 4095);
    checks++;
    if (o_ovf !== 4'b0000) begin errors++; $display("[TB] FAIL ovf_at_max: got %b expected 0000", o_ovf); end
    pulse_evt(1, 1);
    checks++;
    if (o_ovf !== 4'b0010) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 0010", o_ovf); end
    pulse_evt(1, 1);
    get_frame(w);
    checks++;
    if (w !== OVF_FRAME) begin errors++; $display("[TB] FAIL ovf_frame: got %h expected %h", w, OVF_FRAME); end
    checks++;
    if (o_ovf !== 4'b0000) begin errors++; $display("[TB] FAIL ovf_cleared: got %b expected 0000", o_ovf); end
  endtask

  task automatic test_reset_in_hold();
    logic [W-1:0] w;
    int waited;
    pulse_evt(0, 3);
    waited = 0;
    i_tx_req = 1'b1;
    while (o_tx_valid !== 1'b1 && waited < 8) begin
      @(negedge i_clk);
      waited++;
    end
    checks++;
    if (o_tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_reached: got %b expected 1", o_tx_valid); end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_reset_valid: got %b expected 0", o_tx_valid); end
    checks++;
    if (o_tx_word !== 16'h0000) begin errors++; $display("[TB] FAIL hold_reset_word: got %h expected 0000", o_tx_word); end
    i_tx_req = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_sel !== 2'd0) begin errors++; $display("[TB] FAIL hold_reset_sel: got %0d expected 0", o_sel); end
    checks++;
    if (o_ovf !== 4'b0000) begin errors++; $display("[TB] FAIL hold_reset_ovf: got %b expected 0000", o_ovf); end
    get_frame(w);
    checks++;
    if (w !== 16'h0000) begin errors++; $display("[TB] FAIL hold_reset_frame: got %h expected 0000", w); end
  endtask

  initial begin
    $display("[TB] starting prs_tx_feeder bench");
    test_reset();
    test_basic_frame();
    test_command_select();
    test_aborted_request();
    test_snapshot_collision();
    test_sel_during_load();
    test_overflow();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
